// File: rtl/period_meter.sv
// ============================================================================
// Module   : period_meter
// Brief    : Rise-to-rise period measurement of an asynchronous input in clk
//            cycles; optional high-time capture under PERIOD_METER_DUTY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module period_meter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             sig_in_i,
    output logic [WIDTH-1:0] period_o,
    output logic             period_valid_o,
    output logic             timeout_o,
    output logic             busy_o
`ifdef PERIOD_METER_DUTY_EN
    ,
    output logic [WIDTH-1:0] high_time_o
`endif
);

    localparam logic [WIDTH-1:0] c_cnt_max = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d_q;
    logic [WIDTH-1:0]       cnt_q;
    logic [WIDTH-1:0]       period_q;
    logic                   valid_q;
    logic                   timeout_q;
    logic                   busy_q;

    logic                   w_sig_s;
    logic                   w_rise;

    assign w_sig_s = sync_q[SYNC_STAGES-1];
    assign w_rise  = w_sig_s & ~sig_d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            sig_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in_i};
            sig_d_q <= w_sig_s;
        end
    end

`ifdef PERIOD_METER_DUTY_EN
    logic [WIDTH-1:0] hcnt_q;
    logic [WIDTH-1:0] high_q;
    logic [WIDTH-1:0] hcnt_inc;

    // High-cycle accumulator saturates rather than wrapping.
    assign hcnt_inc = (hcnt_q == c_cnt_max) ? hcnt_q
                                            : hcnt_q + {{(WIDTH-1){1'b0}}, w_sig_s};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef PERIOD_METER_DUTY_EN
            hcnt_q    <= '0;
            high_q    <= '0;
`endif
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            if (!enable_i) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
`ifdef PERIOD_METER_DUTY_EN
                hcnt_q  <= '0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // The first rise only arms; no sample is produced.
                        if (w_rise) begin
                            state_q <= S_MEASURE;
                            cnt_q   <= c_one;
                            busy_q  <= 1'b1;
`ifdef PERIOD_METER_DUTY_EN
                            hcnt_q  <= c_one;
`endif
                        end else begin
                            cnt_q   <= '0;
`ifdef PERIOD_METER_DUTY_EN
                            hcnt_q  <= '0;
`endif
                        end
                    end
                    S_MEASURE: begin
                        if (w_rise) begin
                            period_q <= cnt_q;
                            valid_q  <= 1'b1;
                            cnt_q    <= c_one;
`ifdef PERIOD_METER_DUTY_EN
                            high_q   <= hcnt_q;
                            hcnt_q   <= c_one;
`endif
                        end else if (cnt_q == c_cnt_max) begin
                            timeout_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= S_IDLE;
                            busy_q    <= 1'b0;
`ifdef PERIOD_METER_DUTY_EN
                            hcnt_q    <= '0;
`endif
                        end else begin
                            cnt_q  <= cnt_q + c_one;
`ifdef PERIOD_METER_DUTY_EN
                            hcnt_q <= hcnt_inc;
`endif
                        end
                    end
                endcase
            end
        end
    end

    assign period_o       = period_q;
    assign period_valid_o = valid_q;
    assign timeout_o      = timeout_q;
    assign busy_o         = busy_q;
`ifdef PERIOD_METER_DUTY_EN
    assign high_time_o    = high_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_period_meter.sv
// ============================================================================
// Module   : tb_period_meter
// Brief    : Directed plus randomized bench for period_meter against an
//            event-level reference model (rise times, arming, timeout).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_period_meter;

    localparam int W   = 8;
    localparam int SS  = 2;
    localparam int MAX = (1 << W) - 1;
    localparam int HN  = 8191;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         enable = 1'b0;
    logic         sig_in = 1'b0;
    logic [W-1:0] period;
    logic         period_valid;
    logic         timeout;
    logic         busy;
`ifdef PERIOD_METER_DUTY_EN
    logic [W-1:0] high_time;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state: sig_in value driven before each clock edge.
    bit drv [0:HN];
    int m;
    bit armed;
    int last;
    int exp_period, exp_high;
    bit exp_valid, exp_to;
    bit sig, en;
    int n_valid, n_to;

    period_meter #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .sig_in_i       (sig_in),
        .period_o       (period),
        .period_valid_o (period_valid),
        .timeout_o      (timeout),
        .busy_o         (busy)
`ifdef PERIOD_METER_DUTY_EN
        ,
        .high_time_o    (high_time)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic bit dget(input int i);
        return (i >= 1 && i <= HN) ? drv[i] : 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i <= HN; i++) drv[i] = 1'b0;
        m = 0; armed = 0; last = 0;
        exp_period = 0; exp_high = 0; exp_valid = 0; exp_to = 0;
    endtask

    task automatic drive();
        sig_in = sig;
        enable = en;
        m++;
        if (m > HN) begin
            chk("history_overflow", 1, 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "bench history exhausted");
        end
        drv[m] = sig;
    endtask

    // The synchronized level seen by the measuring logic at edge m is the
    // input driven SS edges earlier; a rise is a 0->1 step of that level.
    task automatic edge_step();
        bit rise;
        @(posedge clk);
        rise = dget(m - SS) & ~dget(m - SS - 1);
        exp_valid = 0;
        exp_to    = 0;
        if (!en) begin
            armed = 0;
        end else if (rise) begin
            if (armed) begin
                exp_period = m - last;
                exp_high   = 0;
                for (int k = last; k < m; k++) exp_high += dget(k - SS);
                exp_valid  = 1;
            end
            armed = 1;
            last  = m;
        end else if (armed && (m - last) == MAX) begin
            exp_to = 1;
            armed  = 0;
        end
        #1;
        n_valid += period_valid;
        n_to    += timeout;
        chk("valid",   period_valid, exp_valid);
        chk("timeout", timeout, exp_to);
        chk("busy",    busy, armed);
        chk("period",  period, exp_period);
`ifdef PERIOD_METER_DUTY_EN
        chk("high_time", high_time, exp_high);
`endif
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            drive();
            edge_step();
        end
    endtask

    task automatic wave(input int hi, input int lo, input int np);
        repeat (np) begin
            sig = 1; run(hi);
            sig = 0; run(lo);
        end
    endtask

    task automatic release_reset();
        model_clear();
        rst_n = 1'b1;
        drive();
        edge_step();
    endtask

    initial begin
        int hi, lo, r;
        model_clear();
        n_valid = 0; n_to = 0;

        // Reset held with the input toggling.
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sig_in = ~sig_in;
            enable = 1'b1;
            @(posedge clk);
            #1;
            chk("rst_period", period, 0);
            chk("rst_valid",  period_valid, 0);
            chk("rst_timeout", timeout, 0);
            chk("rst_busy",   busy, 0);
        end
        @(negedge clk);
        sig = 0; en = 1;
        release_reset();

        // Square wave P=10, five rises.
        run(3);
        n_valid = 0;
        wave(5, 5, 5);
        run(5);
        chk("p10_nvalid", n_valid, 4);
        chk("p10_period", period, 10);

        // Single arming rise then silence: timeout.
        en = 0; run(2); en = 1;
        n_to = 0; n_valid = 0;
        sig = 1; run(2);
        sig = 0; run(300);
        chk("to_count",  n_to, 1);
        chk("to_nvalid", n_valid, 0);
        chk("to_busy",   busy, 0);
        chk("to_period", period, 10);

        // Rise exactly at counter max wins over timeout.
        n_to = 0; n_valid = 0;
        sig = 1; run(1); sig = 0; run(254);
        sig = 1; run(1); sig = 0; run(10);
        chk("p255_nvalid", n_valid, 1);
        chk("p255_nto",    n_to, 0);
        chk("p255_period", period, 255);

        // One cycle longer times out and the late rise only re-arms.
        en = 0; run(1); en = 1;
        n_to = 0; n_valid = 0;
        sig = 1; run(1); sig = 0; run(255);
        sig = 1; run(1); sig = 0; run(3);
        chk("p256_nto",    n_to, 1);
        chk("p256_nvalid", n_valid, 0);
        chk("p256_period", period, 255);
        chk("p256_busy",   busy, 1);

        // Period change without re-arming.
        wave(5, 5, 4);
        chk("chg_p10", period, 10);
        wave(10, 27, 3);
        run(3);
        chk("chg_p37", period, 37);

        // Enable dropped between rises.
        wave(5, 5, 3);
        en = 0; n_valid = 0; n_to = 0;
        wave(5, 5, 2);
        chk("dis_nvalid", n_valid, 0);
        chk("dis_nto",    n_to, 0);
        chk("dis_busy",   busy, 0);
        chk("dis_period", period, 10);
        en = 1; n_valid = 0;
        wave(5, 5, 1);
        chk("reen_nvalid_arm", n_valid, 0);
        wave(5, 5, 1);
        run(3);
        chk("reen_nvalid", n_valid, 1);

        // Duty cycle 3 high / 7 low, then asynchronous reset mid-period.
        wave(3, 7, 4);
        chk("duty_period", period, 10);
`ifdef PERIOD_METER_DUTY_EN
        chk("duty_high", high_time, 3);
`endif
        sig = 1; run(2);
        rst_n = 1'b0;
        #1;
        chk("arst_period", period, 0);
        chk("arst_valid",  period_valid, 0);
        chk("arst_busy",   busy, 0);
`ifdef PERIOD_METER_DUTY_EN
        chk("arst_high",   high_time, 0);
`endif
        @(negedge clk);
        sig = 0;
        release_reset();

        // Randomized high/low lengths, occasional long gaps and enable drops.
        run(3);
        repeat (40) begin
            hi = $urandom_range(1, 20);
            lo = $urandom_range(1, 20);
            r  = $urandom_range(0, 9);
            if (r == 0) lo = $urandom_range(240, 270);
            en = (r != 1);
            wave(hi, lo, 1);
        end
        en = 1; sig = 0;
        run(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
